// File: rtl/riscv_pipeline_controller_pkg.sv
// Shared state encodings and the stage-control bundle for the RISC-V pipeline controller.
package riscv_pipeline_controller_pkg;

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMduBusy = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mdu_kill;
  } ctrl_t;

  localparam ctrl_t CtrlDefault = '{
    pc_en:        1'b1,
    if_id_en:     1'b1,
    id_ex_en:     1'b1,
    ex_mem_en:    1'b1,
    mem_wb_en:    1'b1,
    if_id_flush:  1'b0,
    id_ex_flush:  1'b0,
    ex_mem_flush: 1'b0,
    mdu_kill:     1'b0
  };

  // Front end frozen while the mul/div result is pending; EX/MEM gets a bubble.
  function automatic ctrl_t ctrl_mdu_stall();
    ctrl_t c;
    c              = CtrlDefault;
    c.pc_en        = 1'b0;
    c.if_id_en     = 1'b0;
    c.id_ex_en     = 1'b0;
    c.ex_mem_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/riscv_hazard_detect.sv
// Load-use hazard comparator: a used decode source matches a non-x0 load destination.
module riscv_hazard_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_is_load,
  output logic                  o_load_use
);

  logic rd_nonzero;

  assign rd_nonzero = |i_ex_rd;
  assign o_load_use = i_ex_is_load & rd_nonzero &
                      ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                       (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));

endmodule

// File: rtl/riscv_pipeline_controller.sv
// Five-stage pipeline controller: stall/flush decode, MDU and memory-wait FSM, stall counter.
module riscv_pipeline_controller
  import riscv_pipeline_controller_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [REG_ADDR_W-1:0]  i_id_rs1,
  input  logic [REG_ADDR_W-1:0]  i_id_rs2,
  input  logic                   i_id_rs1_used,
  input  logic                   i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0]  i_ex_rd,
  input  logic                   i_ex_is_load,
  input  logic                   i_ex_br_taken,
  input  logic                   i_ex_mdu_start,
  input  logic                   i_mdu_done,
  input  logic                   i_mem_req,
  input  logic                   i_mem_ready,
  input  logic                   i_trap,
  input  logic                   i_stall_cnt_clr,
  output logic                   o_pc_en,
  output logic                   o_if_id_en,
  output logic                   o_id_ex_en,
  output logic                   o_ex_mem_en,
  output logic                   o_mem_wb_en,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_flush,
  output logic                   o_ex_mem_flush,
  output logic                   o_mdu_kill,
  output logic [1:0]             o_state,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  logic [1:0]             state_q, state_d;
  logic                   trap_pend_q, trap_pend_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   load_use;
  logic                   mem_hold;
  ctrl_t                  ctrl;

  riscv_hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .i_ex_rd       (i_ex_rd),
    .i_ex_is_load  (i_ex_is_load),
    .o_load_use    (load_use)
  );

  assign mem_hold = i_mem_req & ~i_mem_ready;

  always_comb begin
    ctrl        = CtrlDefault;
    state_d     = StRun;
    trap_pend_d = 1'b0;
    if (mem_hold) begin
      ctrl.pc_en     = 1'b0;
      ctrl.if_id_en  = 1'b0;
      ctrl.id_ex_en  = 1'b0;
      ctrl.ex_mem_en = 1'b0;
      ctrl.mem_wb_en = 1'b0;
      state_d        = StMemWait;
      // A trap seen during the hold is deferred to the release cycle.
      trap_pend_d    = trap_pend_q | i_trap;
    end else if (i_trap || trap_pend_q) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
      ctrl.ex_mem_flush = 1'b1;
      ctrl.mdu_kill     = (state_q == StMduBusy);
    end else if (state_q == StMemWait) begin
      ctrl = CtrlDefault;
    end else if (state_q == StMduBusy) begin
      if (!i_mdu_done) begin
        ctrl    = ctrl_mdu_stall();
        state_d = StMduBusy;
      end
    end else if (i_ex_mdu_start && !i_mdu_done) begin
      ctrl    = ctrl_mdu_stall();
      state_d = StMduBusy;
    end else if (i_ex_br_taken) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_en    = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (!ctrl.pc_en && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StRun;
      trap_pend_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      trap_pend_q <= trap_pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_pc_en        = ctrl.pc_en;
  assign o_if_id_en     = ctrl.if_id_en;
  assign o_id_ex_en     = ctrl.id_ex_en;
  assign o_ex_mem_en    = ctrl.ex_mem_en;
  assign o_mem_wb_en    = ctrl.mem_wb_en;
  assign o_if_id_flush  = ctrl.if_id_flush;
  assign o_id_ex_flush  = ctrl.id_ex_flush;
  assign o_ex_mem_flush = ctrl.ex_mem_flush;
  assign o_mdu_kill     = ctrl.mdu_kill;
  assign o_state        = state_q;
  assign o_stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_riscv_pipeline_controller.sv
// Directed bench for riscv_pipeline_controller: single-cycle vector table plus multi-cycle sequences.
module tb_riscv_pipeline_controller;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd;
  logic       i_id_rs1_used, i_id_rs2_used, i_ex_is_load, i_ex_br_taken;
  logic       i_ex_mdu_start, i_mdu_done, i_mem_req, i_mem_ready, i_trap, i_stall_cnt_clr;
  logic       o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
  logic       o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mdu_kill;
  logic [1:0] o_state;
  logic [15:0] o_stall_cnt;
  logic [8:0] ctrl;

  // Narrow-counter instance sharing the same stimulus.
  logic       n_pc_en, n_if_id_en, n_id_ex_en, n_ex_mem_en, n_mem_wb_en;
  logic       n_if_id_flush, n_id_ex_flush, n_ex_mem_flush, n_mdu_kill;
  logic [1:0] n_state;
  logic [3:0] n_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  riscv_pipeline_controller dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used), .i_ex_rd(i_ex_rd),
    .i_ex_is_load(i_ex_is_load), .i_ex_br_taken(i_ex_br_taken),
    .i_ex_mdu_start(i_ex_mdu_start), .i_mdu_done(i_mdu_done), .i_mem_req(i_mem_req),
    .i_mem_ready(i_mem_ready), .i_trap(i_trap), .i_stall_cnt_clr(i_stall_cnt_clr),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_id_ex_en(o_id_ex_en),
    .o_ex_mem_en(o_ex_mem_en), .o_mem_wb_en(o_mem_wb_en), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_flush(o_id_ex_flush), .o_ex_mem_flush(o_ex_mem_flush), .o_mdu_kill(o_mdu_kill),
    .o_state(o_state), .o_stall_cnt(o_stall_cnt)
  );

  riscv_pipeline_controller #(.STALL_CNT_W(4), .REG_ADDR_W(5)) dut_narrow (
    .i_clk(i_clk), .i_rst(i_rst), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used), .i_ex_rd(i_ex_rd),
    .i_ex_is_load(i_ex_is_load), .i_ex_br_taken(i_ex_br_taken),
    .i_ex_mdu_start(i_ex_mdu_start), .i_mdu_done(i_mdu_done), .i_mem_req(i_mem_req),
    .i_mem_ready(i_mem_ready), .i_trap(i_trap), .i_stall_cnt_clr(i_stall_cnt_clr),
    .o_pc_en(n_pc_en), .o_if_id_en(n_if_id_en), .o_id_ex_en(n_id_ex_en),
    .o_ex_mem_en(n_ex_mem_en), .o_mem_wb_en(n_mem_wb_en), .o_if_id_flush(n_if_id_flush),
    .o_id_ex_flush(n_id_ex_flush), .o_ex_mem_flush(n_ex_mem_flush), .o_mdu_kill(n_mdu_kill),
    .o_state(n_state), .o_stall_cnt(n_stall_cnt)
  );

  assign ctrl = {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
                 o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mdu_kill};

  // Expected ctrl words: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl, kill}
  localparam logic [8:0] CDef   = 9'b11111_000_0;
  localparam logic [8:0] CLoad  = 9'b00111_010_0;
  localparam logic [8:0] CBr    = 9'b11111_110_0;
  localparam logic [8:0] CMdu   = 9'b00011_001_0;
  localparam logic [8:0] CTrap  = 9'b11111_111_0;
  localparam logic [8:0] CKill  = 9'b11111_111_1;
  localparam logic [8:0] CHold  = 9'b00000_000_0;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, br, ms, md, mr, my, tr;
    logic [8:0] exp_ctrl;
    logic [1:0] exp_state;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t mk(string n, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic ld, logic br, logic ms, logic md,
                              logic mr, logic my, logic tr, logic [8:0] ec, logic [1:0] es);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.ld = ld;
    v.br = br; v.ms = ms; v.md = md; v.mr = mr; v.my = my; v.tr = tr;
    v.exp_ctrl = ec; v.exp_state = es;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_ex_rd = 5'd0;
    i_id_rs1_used = 1'b0; i_id_rs2_used = 1'b0; i_ex_is_load = 1'b0; i_ex_br_taken = 1'b0;
    i_ex_mdu_start = 1'b0; i_mdu_done = 1'b0; i_mem_req = 1'b0; i_mem_ready = 1'b0;
    i_trap = 1'b0; i_stall_cnt_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    idle();
    tv[0]  = mk("idle",          0,0, 0,0, 0,0,0,0,0,0,0,0, CDef,  2'd0);
    tv[1]  = mk("lu_rs1_x5",     5,1, 0,0, 5,1,0,0,0,0,0,0, CLoad, 2'd0);
    tv[2]  = mk("lu_x0",         0,1, 0,1, 0,1,0,0,0,0,0,0, CDef,  2'd0);
    tv[3]  = mk("lu_rs1_unused", 5,0, 3,1, 5,1,0,0,0,0,0,0, CDef,  2'd0);
    tv[4]  = mk("lu_rs2_x7",     1,1, 7,1, 7,1,0,0,0,0,0,0, CLoad, 2'd0);
    tv[5]  = mk("no_load_match", 5,1, 5,1, 5,0,0,0,0,0,0,0, CDef,  2'd0);
    tv[6]  = mk("branch",        0,0, 0,0, 0,0,1,0,0,0,0,0, CBr,   2'd0);
    tv[7]  = mk("branch_over_lu",5,1, 0,0, 5,1,1,0,0,0,0,0, CBr,   2'd0);
    tv[8]  = mk("mdu_start",     0,0, 0,0, 0,0,0,1,0,0,0,0, CMdu,  2'd1);
    tv[9]  = mk("mdu_start_done",0,0, 0,0, 0,0,0,1,1,0,0,0, CDef,  2'd0);
    tv[10] = mk("trap_run",      0,0, 0,0, 0,0,0,0,0,0,0,1, CTrap, 2'd0);
    tv[11] = mk("trap_over_mdu", 0,0, 0,0, 0,0,0,1,0,0,0,1, CTrap, 2'd0);
    tv[12] = mk("mem_hold",      0,0, 0,0, 0,0,0,0,0,1,0,0, CHold, 2'd2);
    tv[13] = mk("mem_ready",     0,0, 0,0, 0,0,0,0,0,1,1,0, CDef,  2'd0);
    tv[14] = mk("hold_over_trap",0,0, 0,0, 0,0,0,0,0,1,0,1, CHold, 2'd2);
    tv[15] = mk("mdu_over_lu",   5,1, 0,0, 5,1,0,1,0,0,0,0, CMdu,  2'd1);
    tv[16] = mk("mdu_over_br",   0,0, 0,0, 0,0,1,1,0,0,0,0, CMdu,  2'd1);

    tick();
    check("reset_state", {30'd0, o_state}, 32'd0);
    check("reset_cnt", {16'd0, o_stall_cnt}, 32'd0);
    i_rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      pulse_reset();
      i_id_rs1 = tv[i].rs1; i_id_rs1_used = tv[i].u1; i_id_rs2 = tv[i].rs2;
      i_id_rs2_used = tv[i].u2; i_ex_rd = tv[i].rd; i_ex_is_load = tv[i].ld;
      i_ex_br_taken = tv[i].br; i_ex_mdu_start = tv[i].ms; i_mdu_done = tv[i].md;
      i_mem_req = tv[i].mr; i_mem_ready = tv[i].my; i_trap = tv[i].tr;
      #1;
      check({tv[i].name, "_ctrl"}, {23'd0, ctrl}, {23'd0, tv[i].exp_ctrl});
      tick();
      check({tv[i].name, "_state"}, {30'd0, o_state}, {30'd0, tv[i].exp_state});
      idle();
    end

    // Load-use: exactly one stall cycle.
    pulse_reset();
    i_ex_is_load = 1'b1; i_ex_rd = 5'd5; i_id_rs1 = 5'd5; i_id_rs1_used = 1'b1;
    #1; check("lu_seq_ctrl", {23'd0, ctrl}, {23'd0, CLoad});
    tick(); idle();
    #1; check("lu_seq_after", {23'd0, ctrl}, {23'd0, CDef});
    check("lu_seq_cnt", {16'd0, o_stall_cnt}, 32'd1);

    // MDU with done four cycles after start.
    pulse_reset();
    i_ex_mdu_start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      i_mdu_done = (c == 4);
      #1;
      check($sformatf("mdu_seq_c%0d", c), {23'd0, ctrl}, {23'd0, (c == 4) ? CDef : CMdu});
      tick();
      i_ex_mdu_start = 1'b0;
    end
    idle();
    check("mdu_seq_state", {30'd0, o_state}, 32'd0);
    check("mdu_seq_cnt", {16'd0, o_stall_cnt}, 32'd4);

    // Trap in the second MDU_BUSY cycle kills the op.
    pulse_reset();
    i_ex_mdu_start = 1'b1;
    tick(); i_ex_mdu_start = 1'b0;
    check("kill_busy1_state", {30'd0, o_state}, 32'd1);
    tick(); i_trap = 1'b1;
    #1; check("kill_ctrl", {23'd0, ctrl}, {23'd0, CKill});
    tick(); idle();
    check("kill_state", {30'd0, o_state}, 32'd0);
    #1; check("kill_after", {23'd0, ctrl}, {23'd0, CDef});

    // Memory hold with a trap in its second cycle, released on ready.
    pulse_reset();
    i_mem_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_trap = (c == 1);
      #1; check($sformatf("memtrap_hold_c%0d", c), {23'd0, ctrl}, {23'd0, CHold});
      tick();
    end
    i_trap = 1'b0; i_mem_ready = 1'b1;
    check("memtrap_wait_state", {30'd0, o_state}, 32'd2);
    #1; check("memtrap_release", {23'd0, ctrl}, {23'd0, CTrap});
    tick(); idle();
    check("memtrap_state", {30'd0, o_state}, 32'd0);
    check("memtrap_cnt", {16'd0, o_stall_cnt}, 32'd3);
    #1; check("memtrap_after", {23'd0, ctrl}, {23'd0, CDef});

    // Memory release with an MDU start still shows default outputs.
    pulse_reset();
    i_mem_req = 1'b1;
    tick(); i_mem_ready = 1'b1; i_ex_mdu_start = 1'b1;
    #1; check("mem_release_dflt", {23'd0, ctrl}, {23'd0, CDef});
    tick(); idle();
    check("mem_release_state", {30'd0, o_state}, 32'd0);

    // Saturation of the narrow counter and clear-over-increment.
    pulse_reset();
    i_mem_req = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("sat_wide_cnt", {16'd0, o_stall_cnt}, 32'd20);
    check("sat_narrow_cnt", {28'd0, n_stall_cnt}, 32'd15);
    i_stall_cnt_clr = 1'b1;
    tick(); idle();
    check("clr_wide_cnt", {16'd0, o_stall_cnt}, 32'd0);
    check("clr_narrow_cnt", {28'd0, n_stall_cnt}, 32'd0);

    // Asynchronous reset mid-MDU stall.
    i_ex_mdu_start = 1'b1;
    tick(); tick();
    check("rst_pre_state", {30'd0, o_state}, 32'd1);
    i_rst = 1'b1;
    #1;
    check("rst_async_state", {30'd0, o_state}, 32'd0);
    check("rst_async_cnt", {16'd0, o_stall_cnt}, 32'd0);
    i_rst = 1'b0; idle();
    #1; check("rst_after_ctrl", {23'd0, ctrl}, {23'd0, CDef});
    tick();
    check("rst_after_state", {30'd0, o_state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
